// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO write service.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier magnitude is zero.
module muldiv_hilo_unit #(
  parameter int WORD_LEN = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] val1,
  input  logic [WORD_LEN-1:0] val2,
  input  logic                mthi,
  input  logic                mtlo,
  input  logic [WORD_LEN-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [WORD_LEN-1:0] HI,
  output logic [WORD_LEN-1:0] LO
);

  localparam int W2 = 2 * WORD_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                is_div, neg_q, neg_r, dz;
  logic [WORD_LEN-1:0] val1_raw, mplier;
  logic [W2-1:0]       acc, mcand, prod;
  logic [WORD_LEN:0]   trial;
  logic                start_ok, op_signed, early_out;
  logic [WORD_LEN-1:0] mag1, mag2, hi_res, lo_res;

  // Two's-complement magnitude; the most-negative value maps onto its own unsigned pattern.
  function automatic logic [WORD_LEN-1:0] magnitude(input logic [WORD_LEN-1:0] v, input logic sgn);
    return (sgn && v[WORD_LEN-1]) ? -v : v;
  endfunction

  function automatic logic [WORD_LEN-1:0] neg_w(input logic [WORD_LEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign start_ok  = (state == IDLE) && start;
  assign op_signed = ~op[0];
  assign mag1      = magnitude(val1, op_signed);
  assign mag2      = magnitude(val2, op_signed);

  // Restoring step: shifted partial remainder (WORD_LEN+1 bits) minus divisor; MSB set means restore.
  assign trial = acc[W2-1:WORD_LEN-1] - {1'b0, mcand[WORD_LEN-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !is_div && (mplier == '0);
`else
  assign early_out = 1'b0;
`endif

  // Keep busy through the done cycle so the stall releases only once HI/LO are visible.
  assign busy = (state != IDLE) || done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (early_out || cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign prod = neg_2w(acc, neg_q);

  always_comb begin
    hi_res = prod[W2-1:WORD_LEN];
    lo_res = prod[WORD_LEN-1:0];
    if (is_div) begin
      lo_res = neg_w(acc[WORD_LEN-1:0], neg_q);
      hi_res = neg_w(acc[W2-1:WORD_LEN], neg_r);
      if (dz) begin
        lo_res = '1;
        hi_res = val1_raw;
      end
    end
  end

  // Datapath: operand capture at start, one shift-add or restoring step per RUN cycle.
  always_ff @(posedge clock) begin
    if (start_ok) begin
      is_div   <= op[1];
      neg_q    <= op_signed && (val1[WORD_LEN-1] ^ val2[WORD_LEN-1]);
      neg_r    <= op_signed && val1[WORD_LEN-1];
      dz       <= op[1] && (val2 == '0);
      val1_raw <= val1;
      mplier   <= mag2;
      if (op[1]) begin
        acc   <= {{WORD_LEN{1'b0}}, mag1};
        mcand <= {{WORD_LEN{1'b0}}, mag2};
      end else begin
        acc   <= '0;
        mcand <= {{WORD_LEN{1'b0}}, mag1};
      end
    end else if (state == RUN) begin
      if (is_div) begin
        if (!trial[WORD_LEN])
          acc <= {trial[WORD_LEN-1:0], acc[WORD_LEN-2:0], 1'b1};
        else
          acc <= {acc[W2-2:0], 1'b0};
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  // Control and architectural registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= CNT_W'(WORD_LEN);
            div_by_zero <= 1'b0;
          end else begin
            if (mthi) HI <= wr_data;
            if (mtlo) LO <= wr_data;
          end
        end
        RUN:    cnt <= cnt - CNT_W'(1);
        FINISH: begin
          HI          <= hi_res;
          LO          <= lo_res;
          div_by_zero <= dz;
          cnt         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: expected HI/LO/div_by_zero queued at launch, checked on done.
module tb_muldiv_hilo_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] val1, val2, wr_data;
  logic        mthi, mtlo;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t scoreboard[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_hilo_unit #(.WORD_LEN(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .val1(val1), .val2(val2), .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Reference results {HI,LO} from plain wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sbv;
    case (o)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa  = a;
        sbv = b;
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat_for(input logic [1:0] o, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      int n;
      logic [31:0] m;
      n = 0;
      if (!o[1]) begin
        m = (!o[0] && b[31]) ? -b : b;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        lat = (n + 2 < 33) ? n + 2 : 33;
      end
    end
`endif
    return lat;
  endfunction

  // Drive one start; the start edge is edge 0. Inputs are scrambled afterwards.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mt, input logic [31:0] hi_hold);
    @(negedge clock);
    start = 1'b1; op = o; val1 = a; val2 = b;
    if (with_mt) begin
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
    end
    @(posedge clock); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    val1 = $urandom; val2 = $urandom; op = 2'($urandom_range(0, 3));
    if (with_mt) check_eq("mt_dropped_on_start", HI, hi_hold);
    check_eq("dz_cleared_on_start", div_by_zero, 1'b0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input bit with_mt, input logic [31:0] hi_hold, input bit inject);
    exp_t e;
    int   lat;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    scoreboard.push_back(e);
    start_op(o, a, b, with_mt, hi_hold);
    lat = 61;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (inject && k == 5) begin
        start = 1'b1; op = 2'b11; val1 = 32'd9; val2 = 32'd3;
        mthi = 1'b1; wr_data = 32'h1234;
      end else if (inject && k == 6) begin
        start = 1'b0; mthi = 1'b0;
      end
      if (k == 1) check_eq("busy_edge1", busy, 1'b1);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(lat_for(o, b)));
    check_eq("busy_in_done_cycle", busy, 1'b1);
    @(posedge clock); #1;
    check_eq("busy_after_done", busy, 1'b0);
    check_eq("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [63:0] r;
    r = model(o, a, b);
    run_op(o, a, b, r[63:32], r[31:0], o[1] && (b == 32'h0), 1'b0, 32'h0, inject);
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (scoreboard.size() == 0) begin
        check_eq("done_without_op", done, 1'b0);
      end else begin
        mon_e = scoreboard.pop_front();
        check_eq("HI", HI, mon_e.hi);
        check_eq("LO", LO, mon_e.lo);
        check_eq("div_by_zero", div_by_zero, mon_e.dz);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    reset = 1'b1; start = 1'b0; op = 2'b00; val1 = '0; val2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_HI", HI, 32'h0);
    check_eq("rst_LO", LO, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dz", div_by_zero, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_eq("dz_held_idle", div_by_zero, 1'b1);

    // Most-negative / -1, with MTHI/MTLO asserted alongside start (start wins).
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0064, 1'b0);

    // Start and MTHI while busy must not disturb the running MULT.
    run_model(2'b00, 32'h0001_2345, 32'hFFFF_0000, 1'b1);
    r = model(2'b00, 32'h0001_2345, 32'hFFFF_0000);

    @(negedge clock);
    mthi = 1'b1; wr_data = 32'h1234;
    @(posedge clock); #1;
    mthi = 1'b0;
    check_eq("mthi_HI", HI, 32'h1234);
    check_eq("mthi_LO_kept", LO, r[31:0]);
    @(negedge clock);
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check_eq("mthi_mtlo_HI", HI, 32'hCAFE_F00D);
    check_eq("mthi_mtlo_LO", LO, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a DIV.
    start_op(2'b10, 32'd1000, 32'd7, 1'b0, 32'h0);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_eq("midrst_HI", HI, 32'h0);
    check_eq("midrst_LO", LO, 32'h0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check_eq("midrst_idle_busy", busy, 1'b0);
    run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1'b0, 32'h0, 1'b0);

    run_op(2'b01, 32'd5, 32'd3, 32'h0, 32'd15, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_model(2'(i % 4), a, b, 1'b0);
    end

    repeat (3) @(posedge clock);
    #1;
    check_eq("scoreboard_drained", 64'(scoreboard.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
